// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op and state encodings, widths.
package shift_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/shift.sv
// Combinational shift unit. cf is the last bit shifted out (0 for amount 0
// or when no strobe is active, in which case dst passes through).
module shift
    import shift_pkg::*;
(
    input  logic              left,
    input  logic              right,
    input  logic              math_shift,
    input  logic [AMT_W-1:0]  amount,
    input  logic [DATA_W-1:0] dst,
    output logic [DATA_W-1:0] result,
    output logic              cf
);

    logic [DATA_W:0] wide;

    // Shift with one guard bit to catch the carry-out.
    always_comb begin
        result = dst;
        cf     = 1'b0;
        wide   = '0;
        if (left) begin
            wide   = {1'b0, dst} << amount;
            result = wide[DATA_W-1:0];
            cf     = wide[DATA_W];
        end else if (right) begin
            wide   = {dst, 1'b0} >> amount;
            result = wide[DATA_W:1];
            cf     = wide[0];
        end else if (math_shift) begin
            wide   = $signed({dst, 1'b0}) >>> amount;
            result = wide[DATA_W:1];
            cf     = wide[0];
        end
    end

endmodule

// File: rtl/shift_arb.sv
// Arbitrates NREQ requesters onto one shift unit: accept -> EXEC -> RESP.
// Build option SHIFT_ARB_RR_EN: round-robin arbitration; otherwise fixed
// priority with the lowest index winning.
module shift_arb
    import shift_pkg::*;
#(
    parameter int unsigned NREQ = 2
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [DATA_W*NREQ-1:0] req_src,
    input  logic [DATA_W*NREQ-1:0] req_dst,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_cf,
    input  logic                   rsp_ready
);

    localparam int unsigned ID_W = 2;

    state_e            state;
    logic              ready_en;
    op_e               op_q;
    logic [AMT_W-1:0]  amt_q;
    logic [DATA_W-1:0] dst_q;
    logic [ID_W-1:0]   id_q;

`ifdef SHIFT_ARB_RR_EN
    logic [ID_W-1:0]   ptr;
`endif

    logic              grant_found_c;
    logic [ID_W-1:0]   grant_idx_c;
    logic              accept_win_c;
    logic              accept_c;
    op_e               sel_op_c;
    logic [AMT_W-1:0]  sel_amt_c;
    logic [DATA_W-1:0] sel_dst_c;
    logic              sh_left;
    logic              sh_right;
    logic              sh_math;
    logic [DATA_W-1:0] sh_result;
    logic              sh_cf;
    logic              unused_src;

    // Upper bits of each shift-amount word are ignored.
    assign unused_src = ^req_src;

    // Pick one valid requester, searching from the pointer (or from 0).
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef SHIFT_ARB_RR_EN
            idx = (32'(ptr) + k) % NREQ;
`else
            idx = k;
`endif
            if (!grant_found_c && req_valid[idx]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = ID_W'(idx);
            end
        end
    end

    // New work is taken when idle, or while the current response drains.
    assign accept_win_c = ready_en &&
                          ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    assign accept_c     = accept_win_c && grant_found_c;

    // One-hot accept toward the granted requester only.
    always_comb begin
        req_ready = '0;
        if (accept_c) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    assign sel_op_c  = op_e'(req_op[2*grant_idx_c +: 2]);
    assign sel_amt_c = req_src[DATA_W*grant_idx_c +: AMT_W];
    assign sel_dst_c = req_dst[DATA_W*grant_idx_c +: DATA_W];

    // Shift strobes come from captured state only; reserved op drives none.
    assign sh_left  = (state == ST_EXEC) && (op_q == OP_SLL);
    assign sh_right = (state == ST_EXEC) && (op_q == OP_SRL);
    assign sh_math  = (state == ST_EXEC) && (op_q == OP_SRA);

    shift u_shift (
        .left       (sh_left),
        .right      (sh_right),
        .math_shift (sh_math),
        .amount     (amt_q),
        .dst        (dst_q),
        .result     (sh_result),
        .cf         (sh_cf)
    );

    // Control FSM, operand capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ready_en   <= 1'b0;
            op_q       <= OP_SLL;
            amt_q      <= '0;
            dst_q      <= '0;
            id_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cf     <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            ptr        <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            if (accept_c) begin
                op_q  <= sel_op_c;
                amt_q <= sel_amt_c;
                dst_q <= sel_dst_c;
                id_q  <= grant_idx_c;
`ifdef SHIFT_ARB_RR_EN
                ptr   <= ID_W'((32'(grant_idx_c) + 1) % NREQ);
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_q;
                    rsp_result <= sh_result;
                    rsp_cf     <= sh_cf;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept_c ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: directed scenarios then random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_shift_arb;

    localparam int unsigned NREQ = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_src;
    logic [32*NREQ-1:0]   req_dst;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_cf;
    logic                 rsp_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: one job in the execute slot, one response on show.
    bit          m_exec;
    bit          m_vis;
    bit          m_ready_en;
    int          m_ptr;
    logic [34:0] m_pend;     // {id, cf, result}
    logic [34:0] m_rsp;

    logic [NREQ-1:0] last_req_ready;
    int              got_ids[$];

    shift_arb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cf     (rsp_cf),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {cf, result} from the op definitions.
    function automatic logic [32:0] ref_shift(input logic [1:0] op, input int amt, input logic [31:0] d);
        logic [31:0] r;
        logic        c;
        r = d;
        c = 1'b0;
        case (op)
            2'b00: begin
                r = d << amt;
                c = (amt == 0) ? 1'b0 : d[32-amt];
            end
            2'b01: begin
                r = d >> amt;
                c = (amt == 0) ? 1'b0 : d[amt-1];
            end
            2'b10: begin
                r = d >> amt;
                if (d[31]) r = r | ~(32'hFFFF_FFFF >> amt);
                c = (amt == 0) ? 1'b0 : d[amt-1];
            end
            default: begin
                r = d;
                c = 1'b0;
            end
        endcase
        return {c, r};
    endfunction

    function automatic int arb(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_exec     = 1'b0;
        m_vis      = 1'b0;
        m_ready_en = 1'b0;
        m_ptr      = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [1:0] op,
                           input logic [31:0] src, input logic [31:0] dst);
        req_valid[i]        = v;
        req_op[2*i +: 2]    = op;
        req_src[32*i +: 32] = src;
        req_dst[32*i +: 32] = dst;
    endtask

    // One clock cycle: compare at the falling edge, advance the model,
    // return just after the next rising edge so the caller can drive inputs.
    task automatic step();
        bit              win;
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              nxt_vis;
        @(negedge clk);
        win = rst_n && m_ready_en && !m_exec && (!m_vis || rsp_ready);
        g   = win ? arb(req_valid, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_vis);
        if (m_vis) begin
            check("rsp_id", rsp_id, m_rsp[34:33]);
            check("rsp_cf", rsp_cf, m_rsp[32]);
            check("rsp_result", rsp_result, m_rsp[31:0]);
        end
        last_req_ready = req_ready;
        if (rsp_valid && rsp_ready) got_ids.push_back(int'(rsp_id));
        if (!rst_n) begin
            m_reset();
        end else begin
            nxt_vis = m_vis && !rsp_ready;
            if (m_exec) begin
                nxt_vis = 1'b1;
                m_rsp   = m_pend;
            end
            m_exec = (g >= 0);
            if (g >= 0) begin
                m_pend = {2'(g), ref_shift(req_op[2*g +: 2], int'(req_src[32*g +: 5]),
                                           req_dst[32*g +: 32])};
`ifdef SHIFT_ARB_RR_EN
                m_ptr = (g + 1) % NREQ;
`endif
            end
            m_vis      = nxt_vis;
            m_ready_en = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && (m_vis || m_exec); k++) step();
        step();
        check("drain_idle", rsp_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] snap_res;
        logic [1:0]  snap_id;
        logic        snap_cf;
        int          exp_ids[4];
        logic [31:0] rs;

        m_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_src   = '0;
        req_dst   = '0;
        rsp_ready = 1'b1;
        last_req_ready = '0;
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_id", rsp_id, 2'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_cf", rsp_cf, 1'b0);
        check("reset_req_ready", req_ready, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();                       // no accept before first edge after release
        check("post_reset_ready_low", last_req_ready, '0);
        req_valid = '0;
        step();

        // Single left shift from requester 0.
        set_req(0, 1'b1, 2'b00, 32'd4, 32'h0000_00F1);
        step();
        check("sll_accept", last_req_ready, 2'b01);
        req_valid = '0;
        check("sll_exec_no_rsp", rsp_valid, 1'b0);
        step();
        check("sll_rsp_valid", rsp_valid, 1'b1);
        check("sll_result", rsp_result, 32'h0000_0F10);
        check("sll_id", rsp_id, 2'd0);
        step();

        // Arithmetic right shift from requester 1; upper src bits ignored.
        set_req(1, 1'b1, 2'b10, 32'h24, 32'h8000_0000);
        step();
        req_valid = '0;
        step();
        check("sra_result", rsp_result, 32'hF800_0000);
        check("sra_id", rsp_id, 2'd1);
        step();
        drain();

        // Contention: both requesters valid throughout.
        got_ids.delete();
        set_req(0, 1'b1, 2'b01, 32'd2, 32'h0000_0100);
        set_req(1, 1'b1, 2'b00, 32'd1, 32'h0000_0005);
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && got_ids.size() < 4; k++) step();
        check("contention_count", got_ids.size(), 4);
`ifdef SHIFT_ARB_RR_EN
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 1;
`else
        exp_ids[0] = 0; exp_ids[1] = 0; exp_ids[2] = 0; exp_ids[3] = 0;
`endif
        for (int k = 0; k < 4 && k < got_ids.size(); k++) begin
            check($sformatf("contention_id%0d", k), got_ids[k], exp_ids[k]);
        end
        drain();

        // Backpressure: response held, no accepts, then same-cycle accept.
        set_req(0, 1'b1, 2'b01, 32'd3, 32'h0000_00F0);
        rsp_ready = 1'b0;
        step();
        step();
        snap_res = rsp_result;
        snap_id  = rsp_id;
        snap_cf  = rsp_cf;
        set_req(0, 1'b1, 2'b00, 32'd1, 32'h0000_0003);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_ready_low", last_req_ready, '0);
            check("bp_valid_hold", rsp_valid, 1'b1);
            check("bp_result_hold", rsp_result, snap_res);
            check("bp_id_hold", rsp_id, snap_id);
            check("bp_cf_hold", rsp_cf, snap_cf);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_same_cycle_accept", last_req_ready, 2'b01);
        req_valid = '0;
        check("bp_exec_no_rsp", rsp_valid, 1'b0);
        step();
        check("bp_next_rsp_valid", rsp_valid, 1'b1);
        check("bp_next_result", rsp_result, 32'h0000_0006);
        step();
        drain();

        // Reserved op passes dst through with cf clear.
        set_req(1, 1'b1, 2'b11, 32'd7, 32'h1234_5678);
        step();
        req_valid = '0;
        step();
        check("rsv_result", rsp_result, 32'h1234_5678);
        check("rsv_cf", rsp_cf, 1'b0);
        step();
        drain();

        // Reset while a job is executing.
        set_req(0, 1'b1, 2'b00, 32'd1, 32'h0000_0001);
        set_req(1, 1'b1, 2'b01, 32'd1, 32'h0000_0002);
        step();
        rst_n = 1'b0;
        m_reset();
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_req_ready", req_ready, '0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_release_ready_low", last_req_ready, '0);
        step();
        check("rst_first_grant", last_req_ready, 2'b01);
        req_valid = '0;
        step();
        check("rst_new_rsp_valid", rsp_valid, 1'b1);
        check("rst_new_rsp_id", rsp_id, 2'd0);
        step();
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                rs = $urandom;
                if ($urandom_range(3) == 0) rs[4:0] = 5'd0;
                set_req(i, ($urandom_range(2) != 0), 2'($urandom_range(3)), rs, $urandom);
            end
            rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
